// File: rtl/register_file.sv
// register_file: architectural registers with ROB rename tags, commit bypass and rollback flush.
module register_file #(
  parameter int REG_NUM   = 32,
  parameter int REG_POS_W = 5,
  parameter int DATA_W    = 32,
  parameter int ROB_ID_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [REG_POS_W-1:0] rs1_from_dsp,
  input  logic [REG_POS_W-1:0] rs2_from_dsp,
  output logic [DATA_W-1:0]    V1_to_dsp,
  output logic [ROB_ID_W-1:0]  Q1_to_dsp,
  output logic [DATA_W-1:0]    V2_to_dsp,
  output logic [ROB_ID_W-1:0]  Q2_to_dsp,
  input  logic                 ena_from_dsp,
  input  logic [REG_POS_W-1:0] rd_from_dsp,
  input  logic [ROB_ID_W-1:0]  rob_id_from_dsp,
  input  logic                 commit_flag_from_rob,
  input  logic [REG_POS_W-1:0] rd_from_rob,
  input  logic [ROB_ID_W-1:0]  Q_from_rob,
  input  logic [DATA_W-1:0]    V_from_rob,
  input  logic                 rollback_flag_from_rob
);
  logic [DATA_W-1:0]   val [REG_NUM];
  logic [ROB_ID_W-1:0] tag [REG_NUM];
  logic commit_ok, release_ok, byp1, byp2;
  always_comb begin
    commit_ok  = commit_flag_from_rob && rd_from_rob != '0;
    release_ok = commit_ok && tag[rd_from_rob] == Q_from_rob;
    byp1       = release_ok && rd_from_rob == rs1_from_dsp;
    byp2       = release_ok && rd_from_rob == rs2_from_dsp;
    V1_to_dsp  = rs1_from_dsp == '0 ? '0 : byp1 ? V_from_rob : val[rs1_from_dsp];
    Q1_to_dsp  = rs1_from_dsp == '0 || byp1 ? '0 : tag[rs1_from_dsp];
    V2_to_dsp  = rs2_from_dsp == '0 ? '0 : byp2 ? V_from_rob : val[rs2_from_dsp];
    Q2_to_dsp  = rs2_from_dsp == '0 || byp2 ? '0 : tag[rs2_from_dsp];
  end
  // later rename assignment deliberately overrides the commit release on the same register
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val[i] <= '0;
        tag[i] <= '0;
      end
    end else if (rdy) begin
      if (commit_ok) val[rd_from_rob] <= V_from_rob;
      if (rollback_flag_from_rob) begin
        for (int i = 0; i < REG_NUM; i++) tag[i] <= '0;
      end else begin
        if (release_ok) tag[rd_from_rob] <= '0;
        if (ena_from_dsp && rd_from_dsp != '0) tag[rd_from_dsp] <= rob_id_from_dsp;
      end
    end
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed plan checks plus randomized traffic against an array reference model.
module tb_register_file;
  logic        clk = 0, rst, rdy, ena, cf, rb;
  logic [4:0]  rs1, rs2, rdd, rdr, rid, qr;
  logic [31:0] vr, v1, v2;
  logic [4:0]  q1, q2;
  logic [31:0] m_val [32];
  logic [4:0]  m_tag [32];
  int checks = 0, failures = 0;

  register_file dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rs1_from_dsp(rs1), .rs2_from_dsp(rs2),
    .V1_to_dsp(v1), .Q1_to_dsp(q1), .V2_to_dsp(v2), .Q2_to_dsp(q2),
    .ena_from_dsp(ena), .rd_from_dsp(rdd), .rob_id_from_dsp(rid),
    .commit_flag_from_rob(cf), .rd_from_rob(rdr), .Q_from_rob(qr), .V_from_rob(vr),
    .rollback_flag_from_rob(rb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_v(input logic [4:0] r);
    if (r == 0) return 0;
    if (cf && rdr == r && m_tag[r] == qr) return vr;
    return m_val[r];
  endfunction

  function automatic logic [4:0] exp_q(input logic [4:0] r);
    if (r == 0) return 0;
    if (cf && rdr == r && m_tag[r] == qr) return 0;
    return m_tag[r];
  endfunction

  task automatic idle();
    rst = 1; rdy = 1; ena = 0; cf = 0; rb = 0;
    rdd = 0; rdr = 0; rid = 0; qr = 0; vr = 0;
  endtask

  task automatic cyc();
    logic [4:0] nt [32];
    #1;
    chk("m_v1", v1, exp_v(rs1));
    chk("m_q1", {27'd0, q1}, {27'd0, exp_q(rs1)});
    chk("m_v2", v2, exp_v(rs2));
    chk("m_q2", {27'd0, q2}, {27'd0, exp_q(rs2)});
    @(posedge clk);
    nt = m_tag;
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin m_val[i] = 0; nt[i] = 0; end
    end else if (rdy) begin
      if (cf && rdr != 0) m_val[rdr] = vr;
      if (rb) for (int i = 0; i < 32; i++) nt[i] = 0;
      else begin
        if (cf && rdr != 0 && m_tag[rdr] == qr) nt[rdr] = 0;
        if (ena && rdd != 0) nt[rdd] = rid;
      end
    end
    m_tag = nt;
    @(negedge clk);
  endtask

  task automatic rename(input logic [4:0] r, input logic [4:0] id);
    idle(); ena = 1; rdd = r; rid = id; cyc();
  endtask

  task automatic rd2(input logic [4:0] a, input logic [4:0] b);
    rs1 = a; rs2 = b; #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_val[i] = 'x; m_tag[i] = 'x; end
    rs1 = 0; rs2 = 0;
    @(negedge clk);
    idle(); rst = 0; cyc();
    idle(); rd2(5, 0);
    chk("rst_v1", v1, 0); chk("rst_q1", {27'd0, q1}, 0);
    chk("rst_v2", v2, 0); chk("rst_q2", {27'd0, q2}, 0);
    cyc();
    cf = 1; rdr = 0; vr = 32'hDEAD; cyc();
    idle(); rd2(0, 0); chk("x0_v", v1, 0); chk("x0_q", {27'd0, q1}, 0);
    rename(3, 4);
    idle(); rd2(3, 0); chk("x3_q", {27'd0, q1}, 4);
    cf = 1; rdr = 3; qr = 4; vr = 32'h1234; #1;
    chk("x3_byp_v", v1, 32'h1234); chk("x3_byp_q", {27'd0, q1}, 0);
    cyc();
    idle(); rd2(3, 0); chk("x3_st_v", v1, 32'h1234); chk("x3_st_q", {27'd0, q1}, 0);
    rename(7, 2); rename(7, 5);
    idle(); cf = 1; rdr = 7; qr = 2; vr = 32'h11; cyc();
    idle(); rd2(7, 0); chk("x7_stale_v", v1, 32'h11); chk("x7_stale_q", {27'd0, q1}, 5);
    cf = 1; rdr = 7; qr = 5; vr = 32'h22; cyc();
    idle(); rd2(0, 7); chk("x7_v", v2, 32'h22); chk("x7_q", {27'd0, q2}, 0);
    rename(9, 3);
    idle(); ena = 1; rdd = 9; rid = 6; cf = 1; rdr = 9; qr = 3; vr = 32'hAA; rd2(9, 0);
    chk("x9_byp_v", v1, 32'hAA); chk("x9_byp_q", {27'd0, q1}, 0);
    cyc();
    idle(); rd2(9, 0); chk("x9_v", v1, 32'hAA); chk("x9_q", {27'd0, q1}, 6);
    rename(1, 1); rename(2, 2); rename(4, 3);
    idle(); rb = 1; cf = 1; rdr = 1; qr = 1; vr = 32'h80; ena = 1; rdd = 5; rid = 4; cyc();
    idle(); rd2(1, 5);
    chk("rb_v1", v1, 32'h80); chk("rb_q1", {27'd0, q1}, 0); chk("rb_q5", {27'd0, q2}, 0);
    rd2(2, 4); chk("rb_q2", {27'd0, q1}, 0); chk("rb_q4", {27'd0, q2}, 0);
    idle(); rdy = 0; ena = 1; rdd = 6; rid = 7; cf = 1; rdr = 6; vr = 32'h55; cyc();
    idle(); rd2(6, 0); chk("hold_v", v1, 0); chk("hold_q", {27'd0, q1}, 0);
    rdy = 0; rst = 0; ena = 1; rdd = 9; rid = 2; cf = 1; rdr = 9; qr = 6; vr = 32'h99; cyc();
    idle(); rd2(9, 7); chk("rst2_v9", v1, 0); chk("rst2_q9", {27'd0, q1}, 0); chk("rst2_v7", v2, 0);
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom_range(63) != 0);
      rdy = ($urandom_range(7) != 0);
      rb  = ($urandom_range(15) == 0);
      ena = $urandom_range(1);
      rdd = 5'($urandom_range(7));
      rid = 5'($urandom_range(31, 1));
      cf  = $urandom_range(1);
      rdr = 5'($urandom_range(7));
      qr  = $urandom_range(1) ? m_tag[rdr] : 5'($urandom_range(31));
      vr  = $urandom;
      rs1 = $urandom_range(1) ? rdr : 5'($urandom_range(7));
      rs2 = 5'($urandom_range(7));
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
